// File: rtl/memory_cell.sv
// memory_cell: one LU-cache entry (data word, priority tag, valid flag).
// Compares the stored word against a lookup key to report a hit.
//
// Ports:
//   clk          rising-edge clock
//   reset        async active-low reset
//   wen          data write enable (also sets valid)
//   priority_wen tag write enable
//   input_data   word to store
//   check_data   lookup key
//   input_addr   new tag value
//   eq           hit: valid and stored word == check_data
//   output_addr  current tag register
//   output_data  current data register
//
// Option macro MEMORY_CELL_EQ_REG_EN: registers eq (one-cycle lag).
module memory_cell #(
  parameter int CELL_SIZE = 8,
  parameter int CELL_ADDR = 0,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wen,
  input  logic                 priority_wen,
  input  logic [CELL_SIZE-1:0] input_data,
  input  logic [CELL_SIZE-1:0] check_data,
  input  logic [ADDR_SIZE-1:0] input_addr,
  output logic                 eq,
  output logic [ADDR_SIZE-1:0] output_addr,
  output logic [CELL_SIZE-1:0] output_data
);

  // Reset tag is the cell index, truncated to the tag width.
  localparam logic [ADDR_SIZE-1:0] RST_ADDR =
    ADDR_SIZE'(CELL_ADDR);

  logic [CELL_SIZE-1:0] data_q;
  logic [CELL_SIZE-1:0] data_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] addr_d;
  logic                 valid_q;
  logic                 valid_d;
  logic                 hit;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    if (wen) begin
      data_d  = input_data;
      valid_d = 1'b1;
    end
    if (priority_wen) begin
      addr_d = input_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      addr_q  <= RST_ADDR;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // An empty cell never hits, even if the key equals the
  // zeroed reset contents.
  assign hit = valid_q && (data_q == check_data);

`ifdef MEMORY_CELL_EQ_REG_EN
  logic eq_q;

  // Samples the pre-write contents against this cycle's key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eq_q <= 1'b0;
    end else begin
      eq_q <= hit;
    end
  end

  assign eq = eq_q;
`else
  assign eq = hit;
`endif

  assign output_data = data_q;
  assign output_addr = addr_q;

endmodule

// File: tb/tb_memory_cell.sv
// tb_memory_cell: scoreboard bench for memory_cell.
// Driver pushes expected outputs; negedge monitor pops and compares.
module tb_memory_cell;

  logic       clk;
  logic       reset;
  logic       wen;
  logic       priority_wen;
  logic [7:0] input_data;
  logic [7:0] check_data;
  logic [7:0] input_addr;
  logic       eq;
  logic [7:0] output_addr;
  logic [7:0] output_data;

  memory_cell #(
    .CELL_SIZE(8),
    .CELL_ADDR(4),
    .ADDR_SIZE(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wen         (wen),
    .priority_wen(priority_wen),
    .input_data  (input_data),
    .check_data  (check_data),
    .input_addr  (input_addr),
    .eq          (eq),
    .output_addr (output_addr),
    .output_data (output_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic [7:0] a;
    logic       e;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: what the cell holds, in plain terms.
  logic [7:0] m_data;
  logic [7:0] m_addr;
  logic       m_valid;
  logic       m_eqr;

  function automatic logic hit_now(logic [7:0] ck);
    return m_valid && (m_data == ck);
  endfunction

  function automatic logic exp_eq(logic [7:0] ck);
`ifdef MEMORY_CELL_EQ_REG_EN
    return m_eqr;
`else
    return hit_now(ck);
`endif
  endfunction

  task automatic model_reset();
    m_data  = 8'h00;
    m_addr  = 8'h04;
    m_valid = 1'b0;
    m_eqr   = 1'b0;
  endtask

  task automatic push(string tag, logic [7:0] ck);
    exp_t e;
    e.tag = tag;
    e.d   = m_data;
    e.a   = m_addr;
    e.e   = exp_eq(ck);
    sbq.push_back(e);
  endtask

  // Called at posedge+1: drive, expect, then apply the edge.
  task automatic step(string tag, logic w, logic pw,
                      logic [7:0] din, logic [7:0] ck,
                      logic [7:0] ad);
    wen          = w;
    priority_wen = pw;
    input_data   = din;
    check_data   = ck;
    input_addr   = ad;
    push(tag, ck);
    @(posedge clk);
    if (reset) begin
      m_eqr = hit_now(ck);
      if (w) begin
        m_data  = din;
        m_valid = 1'b1;
      end
      if (pw) m_addr = ad;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (output_data !== e.d || output_addr !== e.a ||
          eq !== e.e) begin
        errors++;
        $display("FAIL %s: got d=%h a=%h eq=%b want d=%h a=%h eq=%b",
                 e.tag, output_data, output_addr, eq,
                 e.d, e.a, e.e);
      end
    end
  end

  initial begin
    logic [7:0] dn;
    logic [7:0] up;
    logic [7:0] ck;
    reset        = 1'b0;
    wen          = 1'b0;
    priority_wen = 1'b0;
    input_data   = 8'h00;
    check_data   = 8'h00;
    input_addr   = 8'h00;
    model_reset();
    @(posedge clk);
    #1;

    // Held in reset; a write attempt must not land.
    step("rst_hold", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step("rst_wen", 1'b1, 1'b1, 8'h33, 8'h00, 8'h09);
    step("rst_hold2", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    reset = 1'b1;
    step("wr_0f", 1'b1, 1'b0, 8'h0F, 8'h0F, 8'h00);
    step("hit_0f", 1'b0, 1'b0, 8'h00, 8'h0F, 8'h00);
    step("miss_0e", 1'b0, 1'b0, 8'h00, 8'h0E, 8'h00);
    step("pwr_03", 1'b0, 1'b1, 8'h00, 8'h0F, 8'h03);
    step("after_pw", 1'b0, 1'b0, 8'h00, 8'h0F, 8'h00);
    step("both_wr", 1'b1, 1'b1, 8'h0E, 8'h0F, 8'h01);
    step("after_both", 1'b0, 1'b0, 8'h00, 8'h0E, 8'h00);
    step("after_both2", 1'b0, 1'b0, 8'h00, 8'h0F, 8'h00);

    // Toggling enables with wrapping counters.
    dn = 8'h0F;
    up = 8'h00;
    for (int i = 0; i < 270; i++) begin
      step("toggle", i[0] == 1'b0, i[0] == 1'b1,
           dn, up, up);
      dn = dn - 8'h01;
      up = up + 8'h01;
    end

    // Random traffic, keys biased toward the stored word.
    for (int i = 0; i < 300; i++) begin
      ck = ($urandom_range(0, 1) == 1) ? m_data
                                       : 8'($urandom);
      step("rand", 1'($urandom), 1'($urandom),
           8'($urandom), ck, 8'($urandom));
    end

    // Async reset between edges after writes.
    step("pre_rst", 1'b1, 1'b1, 8'h5A, 8'h5A, 8'h22);
    step("pre_rst2", 1'b0, 1'b0, 8'h00, 8'h5A, 8'h00);
    wen          = 1'b1;
    priority_wen = 1'b1;
    input_data   = 8'hA5;
    input_addr   = 8'h11;
    check_data   = 8'h00;
    #2;
    reset = 1'b0;
    model_reset();
    push("async_rst", 8'h00);
    @(posedge clk);
    #1;
    step("rst_wen2", 1'b1, 1'b1, 8'hC3, 8'hC3, 8'h07);
    reset = 1'b1;
    step("post_rst", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step("post_wr", 1'b1, 1'b0, 8'h77, 8'h77, 8'h00);
    step("post_hit", 1'b0, 1'b0, 8'h00, 8'h77, 8'h00);
    step("post_hit2", 1'b0, 1'b0, 8'h00, 8'h77, 8'h00);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_cell.md
# memory_cell

Single storage entry of the LU (least-used) cache. It holds one data word, its priority/address tag and a valid flag, and compares the stored word against a lookup key every cycle. The cache top instantiates an array of these cells, one per `CELL_ADDR`. The replacement logic reads `eq` and `output_addr` to locate hits and to reorder priorities.

## Interface
- `CELL_SIZE`, default 8: width of the stored data word in bits.
- `CELL_ADDR`, default 0: index of this cell in the array. It is also the reset value of the priority tag.
- `ADDR_SIZE`, default 8: width of the priority/address tag in bits. Must be ≥ clog2 of the cell count.
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `wen`, input, 1: data write enable.
- `priority_wen`, input, 1: tag write enable.
- `input_data`, input, `CELL_SIZE`: word to store.
- `check_data`, input, `CELL_SIZE`: lookup key.
- `input_addr`, input, `ADDR_SIZE`: new tag value.
- `eq`, output, 1: hit, meaning valid and stored word == `check_data`.
- `output_addr`, output, `ADDR_SIZE`: current tag register.
- `output_data`, output, `CELL_SIZE`: current data register.

## Operation
- State consists of three registers:
  - `data_r` (`CELL_SIZE`)
  - `addr_r` (`ADDR_SIZE`)
  - `valid_r` (1)
- While `reset`=0, the following hold regardless of clk or enables:
  - `data_r`=0
  - `addr_r`=`CELL_ADDR[ADDR_SIZE-1:0]`
  - `valid_r`=0
- `wen`=1 at a rising edge:
  - `data_r` ← `input_data`.
  - `valid_r` ← 1.
- `priority_wen`=1 at a rising edge: `addr_r` ← `input_addr`.
- The two enables are independent. Both high in the same cycle update both registers in that cycle; no priority between them.
- With neither enable high, all registers hold.
- `output_data` = `data_r` and `output_addr` = `addr_r`, driven directly from the registers.
- `eq` = `valid_r` AND (`data_r` == `check_data`), full-width bitwise compare.
- An invalid cell never hits, including when `check_data`=0 matches the reset contents.
- `valid_r` is cleared only by reset. No invalidate port.
- Data and tag are stored unmodified: no wrap, saturation or arithmetic inside the cell.
- `input_addr` wider values are not possible (port width is fixed at `ADDR_SIZE`).
- `CELL_ADDR` is truncated to `ADDR_SIZE` bits at reset.

## Timing
- Write latency is 1 cycle. A value presented with its enable before edge N is visible on the outputs after edge N.
- `eq` without `MEMORY_CELL_EQ_REG_EN` is combinational:
  - Reflects `check_data` in the same cycle.
  - Reflects a new `data_r` immediately after the write edge.
- Read-during-write: in the cycle `wen` is high, `output_data` and `eq` still show the old contents. New contents appear after the edge.
- Reset asserted mid-operation forces all outputs to reset values asynchronously:
  - `eq`=0
  - `output_data`=0
  - `output_addr`=`CELL_ADDR`
- A write whose edge coincides with reset asserted is discarded.
- Deassertion is released synchronously by the system. The first write is accepted on the first rising edge with `reset`=1.

## Configuration
- Macro: `MEMORY_CELL_EQ_REG_EN`.
- Defined: `eq` is registered, `eq_r` ← `valid_r` && (`data_r` == `check_data`) each rising edge.
  - Hit reported 1 cycle after the key is presented.
  - Reflects the contents before any simultaneous write.
  - `eq_r` resets to 0 asynchronously.
- Undefined: `eq` is purely combinational as described in Operation. No extra flops.

## Test plan
- Reset check, `CELL_SIZE`=8, `CELL_ADDR`=4, `ADDR_SIZE`=8. Hold `reset`=0, `check_data`=0:
  - `output_data`=0x00, `output_addr`=0x04, `eq`=0.
- Release reset, then write `wen`=1, `input_data`=0x0F:
  - Next cycle `output_data`=0x0F.
  - `check_data`=0x0F gives `eq`=1; `check_data`=0x0E gives `eq`=0.
- `priority_wen`=1 with `input_addr`=0x03, `wen`=0:
  - `output_addr`=0x03 after the edge; `output_data` unchanged.
- Both enables high, `input_data`=0x0E, `input_addr`=0x01:
  - Both registers updated in one edge.
  - During that cycle, old values are still on the outputs.
- Toggle `wen`/`priority_wen` every cycle. `input_data` counts down from 0x0F, `check_data` counts up from 0, `input_addr` counts up from 0:
  - `eq`=1 exactly in the cycles where `check_data` equals the last written word.
  - Both counters wrap at 8 bits with no effect on the cell.
- Assert reset asynchronously between clock edges after writes:
  - Outputs return to 0x00 / 0x04 / `eq`=0 immediately.
  - A `wen` on the next edge while reset is low is ignored.
  - With `MEMORY_CELL_EQ_REG_EN`, `eq` lags one cycle in all cases above.
